result_reader: RTL and testbench

- Avalon-MM read master that reads back the 2-word result records the checker wrote into result memory.
- Started by the host-side controller with a base address and record count; fetches each record through mem_if.
- Unpacks each record and pushes a 32-bit record to the upload FIFO (TX side); keeps pass/fail/timeout tallies.
- Sits between mem_if (shared arbiter port) and the host uplink FIFO.

---
 rtl/result_reader_pkg.sv | 12 +
 rtl/result_reader_tally.sv | 37 +++
 rtl/result_reader.sv | 107 ++++++++++
 tb/tb_result_reader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_reader_pkg.sv
// result_reader_pkg: record layout constants and FSM state type shared with the checker writer
package result_reader_pkg;
  localparam int META_VALID  = 7;
  localparam int META_TMO    = 6;
  localparam int META_CYC_HI = 5;
  localparam int META_CYC_LO = 1;
  localparam int META_FAIL   = 0;
  localparam int REC_WORDS   = 2;
  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_CHECK, S_PUSH, S_FINISH
  } state_t;
endpackage

// File: rtl/result_reader_tally.sv
// result_tally: four saturating result counters with synchronous clear
module result_tally #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 i_clear,
  input  logic                 i_inc,
  input  logic                 i_fail,
  input  logic                 i_tmo,
  output logic [CNT_WIDTH-1:0] o_pass_count,
  output logic [CNT_WIDTH-1:0] o_fail_count,
  output logic [CNT_WIDTH-1:0] o_tmo_count,
  output logic [CNT_WIDTH-1:0] o_recs_read
);
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
  // clear on a new run, otherwise count each pushed record, sticking at all-ones
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      o_pass_count <= '0;
      o_fail_count <= '0;
      o_tmo_count  <= '0;
      o_recs_read  <= '0;
    end else if (i_clear) begin
      o_pass_count <= '0;
      o_fail_count <= '0;
      o_tmo_count  <= '0;
      o_recs_read  <= '0;
    end else if (i_inc) begin
      o_recs_read <= sat_inc(o_recs_read);
      if (i_fail) o_fail_count <= sat_inc(o_fail_count);
      else o_pass_count <= sat_inc(o_pass_count);
      if (i_tmo) o_tmo_count <= sat_inc(o_tmo_count);
    end
endmodule

// File: rtl/result_reader.sv
// result_reader: Avalon-MM read master that fetches 2-word result records and pushes them upstream
module result_reader
  import result_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int RTF_WIDTH  = 24,
  parameter int META_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int OF_WIDTH   = RTF_WIDTH + META_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  rec_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_readdatavalid,
  input  logic                  mem_waitrequest,
  output logic [OF_WIDTH-1:0]   ofifo_data,
  output logic                  ofifo_wrreq,
  input  logic                  ofifo_full,
  output logic [CNT_WIDTH-1:0]  pass_count,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [CNT_WIDTH-1:0]  tmo_count,
  output logic [CNT_WIDTH-1:0]  recs_read
);
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_WIDTH-1:0]  r_remaining;
  logic [DATA_WIDTH-1:0] r_hi, r_lo;
  logic                  w_clear;
  assign busy        = r_state != S_IDLE;
  assign mem_address = r_addr;
  assign ofifo_data  = {r_hi, r_lo};
  // next state and Moore/handshake outputs; one read outstanding at a time
  always_comb begin
    w_next      = r_state;
    mem_read    = 1'b0;
    ofifo_wrreq = 1'b0;
    done        = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE:
        if (start) begin
          w_clear = 1'b1;
          w_next  = (rec_count == '0) ? S_FINISH : S_REQ0;
        end
      S_REQ0: begin
        mem_read = 1'b1;
        if (!mem_waitrequest) w_next = S_WAIT0;
      end
      S_WAIT0: if (mem_readdatavalid) w_next = S_REQ1;
      S_REQ1: begin
        mem_read = 1'b1;
        if (!mem_waitrequest) w_next = S_WAIT1;
      end
      S_WAIT1: if (mem_readdatavalid) w_next = S_CHECK;
      S_CHECK: w_next = r_lo[META_VALID] ? S_PUSH : S_FINISH;
      S_PUSH:
        if (!ofifo_full) begin
          ofifo_wrreq = 1'b1;
          w_next      = (r_remaining == CNT_WIDTH'(1)) ? S_FINISH : S_REQ0;
        end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  // state, address walk, captured record words and remaining-record count
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_addr      <= base_addr;
        r_remaining <= rec_count;
      end
      if (mem_read && !mem_waitrequest) r_addr <= r_addr + 1'b1;
      if (r_state == S_WAIT0 && mem_readdatavalid) r_hi <= mem_readdata;
      if (r_state == S_WAIT1 && mem_readdatavalid) r_lo <= mem_readdata;
      if (ofifo_wrreq) r_remaining <= r_remaining - 1'b1;
    end
  result_tally #(.CNT_WIDTH(CNT_WIDTH)) u_tally (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_clear      (w_clear),
    .i_inc        (ofifo_wrreq),
    .i_fail       (r_lo[META_FAIL]),
    .i_tmo        (r_lo[META_TMO]),
    .o_pass_count (pass_count),
    .o_fail_count (fail_count),
    .o_tmo_count  (tmo_count),
    .o_recs_read  (recs_read)
  );
endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: directed checks of result_reader against a memory slave and FIFO model
module tb_result_reader;
  logic        clock = 0, reset_n = 0, start = 0;
  logic [19:0] base_addr = 0;
  logic [15:0] rec_count = 0;
  logic        busy, done, mem_read, ofifo_wrreq;
  logic [19:0] mem_address;
  logic [15:0] mem_readdata = 0;
  logic        mem_readdatavalid = 0, mem_waitrequest = 0, ofifo_full = 0;
  logic [31:0] ofifo_data;
  logic [15:0] pass_count, fail_count, tmo_count, recs_read;

  always #5 clock = ~clock;

  result_reader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .rec_count(rec_count), .busy(busy), .done(done), .mem_address(mem_address),
    .mem_read(mem_read), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
    .ofifo_data(ofifo_data), .ofifo_wrreq(ofifo_wrreq), .ofifo_full(ofifo_full),
    .pass_count(pass_count), .fail_count(fail_count), .tmo_count(tmo_count),
    .recs_read(recs_read)
  );

  int checks = 0, errors = 0;
  logic [15:0] mem [0:63];
  logic [31:0] push_q[$];
  logic [19:0] addr_q[$];
  int stall_cfg = 0, full_cfg = 0, stall_cnt = 0, to_push = 0, full_left = 0, done_cnt = 0;
  logic        pend = 0, pend_odd = 0, held = 0;
  logic [15:0] pend_data = 0;
  logic [19:0] held_addr = 0;
  time         start_t = 0, push_t = 0, done_t = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_push(input int i, input logic [31:0] e);
    check($sformatf("push%0d", i), (i < push_q.size()) ? push_q[i] : 32'hFFFF_FFFF, e);
  endtask

  task automatic chk_addr(input int i, input logic [19:0] e);
    check($sformatf("addr%0d", i), (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hFFFF_FFFF, 32'(e));
  endtask

  task automatic chk_cnt(input string tag, input int p, input int f, input int t, input int r);
    check({tag, "_pass"}, 32'(pass_count), 32'(p));
    check({tag, "_fail"}, 32'(fail_count), 32'(f));
    check({tag, "_tmo"},  32'(tmo_count),  32'(t));
    check({tag, "_recs"}, 32'(recs_read),  32'(r));
  endtask

  // memory slave and FIFO model: inputs change on the falling edge only
  always @(negedge clock) begin
    mem_readdatavalid = pend;
    mem_readdata      = pend_data;
    if (pend && pend_odd) to_push = 3;
    pend = 0;
    if (to_push > 0) begin
      to_push--;
      if (to_push == 0) full_left = full_cfg;
    end
    ofifo_full = full_left > 0;
    if (full_left > 0) full_left--;
    if (mem_read) begin
      if (stall_cnt < stall_cfg) begin
        mem_waitrequest = 1;
        stall_cnt++;
      end else begin
        mem_waitrequest = 0;
        stall_cnt = 0;
        pend = 1;
        pend_data = mem[mem_address[5:0]];
        addr_q.push_back(mem_address);
        pend_odd = (addr_q.size() % 2) == 0;
      end
    end else mem_waitrequest = 0;
  end

  // monitor: samples DUT outputs mid-cycle
  always @(negedge clock) begin
    #2;
    if (held) begin
      check("addr_hold", 32'(mem_address), 32'(held_addr));
      check("read_hold", 32'(mem_read), 32'd1);
    end
    held      = mem_read && mem_waitrequest;
    held_addr = mem_address;
    if (ofifo_full) check("wr_while_full", 32'(ofifo_wrreq), 32'd0);
    if (ofifo_wrreq) begin
      if (push_q.size() == 0) push_t = $time;
      push_q.push_back(ofifo_data);
    end
    if (done) begin
      done_cnt++;
      done_t = $time;
    end
  end

  task automatic run(input logic [19:0] b, input logic [15:0] n);
    int d0;
    push_q.delete();
    addr_q.delete();
    @(negedge clock);
    base_addr = b;
    rec_count = n;
    start = 1;
    start_t = $time;
    d0 = done_cnt;
    @(negedge clock);
    start = 0;
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clock);
    @(negedge clock);
    #3;
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_read", 32'(mem_read), 32'd0);
    check("rst_wr", 32'(ofifo_wrreq), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_data", ofifo_data, 32'd0);
    chk_cnt("rst", 0, 0, 0, 0);
    reset_n = 1;

    mem[6'h10] = 16'hABCD; mem[6'h11] = 16'hEF82;
    run(20'h00010, 16'd1);
    check("t1_npush", 32'(push_q.size()), 32'd1);
    chk_push(0, 32'hABCDEF82);
    chk_addr(0, 20'h00010);
    chk_addr(1, 20'h00011);
    check("t1_latency", 32'(push_t - start_t), 32'd62);
    chk_cnt("t1", 1, 0, 0, 1);

    mem[6'h20] = 16'h1111; mem[6'h21] = 16'h2282;
    mem[6'h22] = 16'h3333; mem[6'h23] = 16'h12C1;
    mem[6'h24] = 16'h5555; mem[6'h25] = 16'h66A4;
    run(20'h00020, 16'd3);
    check("t2_npush", 32'(push_q.size()), 32'd3);
    chk_push(0, 32'h11112282);
    chk_push(1, 32'h333312C1);
    chk_push(2, 32'h555566A4);
    check("t2_nread", 32'(addr_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk_addr(i, 20'h00020 + 20'(i));
    chk_cnt("t2", 2, 1, 1, 3);

    mem[6'h30] = 16'h0102; mem[6'h31] = 16'h0380;
    mem[6'h32] = 16'h0405; mem[6'h33] = 16'h06C0;
    mem[6'h34] = 16'h0708; mem[6'h35] = 16'h0000;
    mem[6'h36] = 16'h090A; mem[6'h37] = 16'h0B81;
    run(20'h00030, 16'd4);
    check("t3_npush", 32'(push_q.size()), 32'd2);
    check("t3_nread", 32'(addr_q.size()), 32'd6);
    chk_push(0, 32'h01020380);
    chk_push(1, 32'h040506C0);
    chk_cnt("t3", 2, 0, 1, 2);

    mem[6'h08] = 16'hA1A2; mem[6'h09] = 16'hB3C3;
    mem[6'h0A] = 16'hC4C5; mem[6'h0B] = 16'hD6E6;
    stall_cfg = 3;
    full_cfg = 5;
    run(20'h00008, 16'd2);
    stall_cfg = 0;
    full_cfg = 0;
    check("t4_npush", 32'(push_q.size()), 32'd2);
    chk_push(0, 32'hA1A2B3C3);
    chk_push(1, 32'hC4C5D6E6);
    for (int i = 0; i < 4; i++) chk_addr(i, 20'h00008 + 20'(i));
    chk_cnt("t4", 1, 1, 2, 2);

    mem[6'h3F] = 16'hBEEF; mem[6'h00] = 16'h1382;
    run(20'hFFFFF, 16'd1);
    chk_addr(0, 20'hFFFFF);
    chk_addr(1, 20'h00000);
    chk_push(0, 32'hBEEF1382);

    run(20'h00010, 16'd0);
    check("t6_nread", 32'(addr_q.size()), 32'd0);
    check("t6_npush", 32'(push_q.size()), 32'd0);
    check("t6_done_t", 32'(done_t - start_t), 32'd12);
    chk_cnt("t6", 0, 0, 0, 0);

    mem[6'h12] = 16'h5A5A; mem[6'h13] = 16'hC1C1;
    push_q.delete();
    addr_q.delete();
    @(negedge clock);
    base_addr = 20'h00010;
    rec_count = 16'd2;
    start = 1;
    @(negedge clock);
    start = 0;
    for (int i = 0; i < 60 && addr_q.size() < 4; i++) @(negedge clock);
    check("t7_reached", 32'(addr_q.size()), 32'd4);
    @(posedge clock);
    #1;
    check("t7_pre_recs", 32'(recs_read), 32'd1);
    reset_n = 0;
    #1;
    check("t7_read", 32'(mem_read), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    chk_cnt("t7", 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    check("t7_npush", 32'(push_q.size()), 32'd1);
    reset_n = 1;
    run(20'h00010, 16'd1);
    check("t8_npush", 32'(push_q.size()), 32'd1);
    chk_push(0, 32'hABCDEF82);
    chk_cnt("t8", 1, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
